// File: rtl/branch_resolve_pkg.sv
// Shared definitions between the fetch-stage static predictor and the
// execute-side branch resolver.
package branch_resolve_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  // RV32 major opcodes the static predictor keys on
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] pre_pc;
    logic                    is_br;
  } pred_entry_t;

endpackage

// File: rtl/branch_resolve_pred_fifo.sv
// In-order prediction queue: synchronous FIFO with a single-cycle clear
// that wins over any push or pop in the same cycle.
module branch_resolve_pred_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~clear;
  assign do_pop  = pop & ~empty & ~clear;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally at DEPTH since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/branch_resolve.sv
// Checks fetch's static predictions against execute's resolved next PC and
// redirects fetch one cycle after a mispredicted (or misaligned) retirement.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic [XLEN-1:0]  if_pc,
  input  logic [XLEN-1:0]  if_pre_pc,
  input  logic             if_is_br,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_next_pc,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  localparam int unsigned ENTRY_W = 2 * XLEN + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [ENTRY_W-1:0] wdata;
  logic [ENTRY_W-1:0] head;
  logic [XLEN-1:0]    head_pc;
  logic [XLEN-1:0]    head_pre_pc;
  logic               head_is_br;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               mismatch;

  // Entry layout {pc, pre_pc, is_br} matches pred_entry_t at default XLEN
  assign wdata = {if_pc, if_pre_pc, if_is_br};
  assign {head_pc, head_pre_pc, head_is_br} = head;

  assign if_ready = ~full & ~redirect_valid;
  assign ex_ready = ~empty;
  assign push     = if_valid & if_ready;
  assign pop      = ex_valid & ex_ready;
  assign mismatch = pop & ((head_pre_pc != ex_next_pc) | (head_pc != ex_pc));

  branch_resolve_pred_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_pred_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (mismatch),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  // Redirect pulse follows the mismatching pop by exactly one cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= mismatch;
      if (mismatch) redirect_pc <= ex_next_pc;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else begin
      if (pop && head_is_br && br_count != CNT_MAX)
        br_count <= br_count + 1'b1;
      if (mismatch && mispred_count != CNT_MAX)
        mispred_count <= mispred_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve; a second instance with 4-bit counters
// shares the stimulus and is checked only for saturation.
module tb_branch_resolve;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_pre_pc;
  logic            if_is_br;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_next_pc;

  logic            if_ready;
  logic            ex_ready;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [31:0]     br_count;
  logic [31:0]     mispred_count;

  logic            s_if_ready;
  logic            s_ex_ready;
  logic            s_redirect_valid;
  logic [XLEN-1:0] s_redirect_pc;
  logic [3:0]      s_br_count;
  logic [3:0]      s_mispred_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branch_resolve #(.DEPTH(4), .XLEN(XLEN), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
    .if_pre_pc(if_pre_pc), .if_is_br(if_is_br),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
    .ex_next_pc(ex_next_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .br_count(br_count), .mispred_count(mispred_count)
  );

  branch_resolve #(.DEPTH(4), .XLEN(XLEN), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_ready(s_if_ready), .if_pc(if_pc),
    .if_pre_pc(if_pre_pc), .if_is_br(if_is_br),
    .ex_valid(ex_valid), .ex_ready(s_ex_ready), .ex_pc(ex_pc),
    .ex_next_pc(ex_next_pc),
    .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc),
    .br_count(s_br_count), .mispred_count(s_mispred_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_if(input logic v, input logic [XLEN-1:0] pc,
                        input logic [XLEN-1:0] pre, input logic br);
    if_valid  = v;
    if_pc     = pc;
    if_pre_pc = pre;
    if_is_br  = br;
  endtask

  task automatic set_ex(input logic v, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] npc);
    ex_valid   = v;
    ex_pc      = pc;
    ex_next_pc = npc;
  endtask

  task automatic idle();
    set_if(1'b0, '0, '0, 1'b0);
    set_ex(1'b0, '0, '0);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;

    check("rst_if_ready", 64'(if_ready), 64'd1);
    check("rst_ex_ready", 64'(ex_ready), 64'd0);
    check("rst_redir_v", 64'(redirect_valid), 64'd0);
    check("rst_redir_pc", 64'(redirect_pc), 64'd0);
    check("rst_br", 64'(br_count), 64'd0);
    check("rst_mis", 64'(mispred_count), 64'd0);

    // Correct predictions
    set_if(1'b1, 32'h100, 32'h104, 1'b0); cyc();
    set_if(1'b1, 32'h104, 32'h0F0, 1'b1); cyc();
    idle();
    check("ok_ex_ready", 64'(ex_ready), 64'd1);
    set_ex(1'b1, 32'h100, 32'h104); cyc();
    check("ok_redir1", 64'(redirect_valid), 64'd0);
    set_ex(1'b1, 32'h104, 32'h0F0); cyc();
    idle();
    check("ok_redir2", 64'(redirect_valid), 64'd0);
    check("ok_br", 64'(br_count), 64'd1);
    check("ok_mis", 64'(mispred_count), 64'd0);
    check("ok_empty", 64'(ex_ready), 64'd0);
    cyc();
    check("ok_redir3", 64'(redirect_valid), 64'd0);

    // Mispredict with a concurrent wrong-path push
    set_if(1'b1, 32'h200, 32'h1F0, 1'b1); cyc();
    set_if(1'b1, 32'h204, 32'h208, 1'b0); cyc();
    set_if(1'b1, 32'h208, 32'h20C, 1'b0); cyc();
    set_if(1'b1, 32'h300, 32'h304, 1'b0);
    set_ex(1'b1, 32'h200, 32'h204);
    check("mp_if_ready_pre", 64'(if_ready), 64'd1);
    cyc();
    idle();
    check("mp_redir_v", 64'(redirect_valid), 64'd1);
    check("mp_redir_pc", 64'(redirect_pc), 64'h204);
    check("mp_if_ready", 64'(if_ready), 64'd0);
    check("mp_ex_ready", 64'(ex_ready), 64'd0);
    check("mp_mis", 64'(mispred_count), 64'd1);
    check("mp_br", 64'(br_count), 64'd2);
    cyc();
    check("mp_redir_drop", 64'(redirect_valid), 64'd0);
    check("mp_push_dropped", 64'(ex_ready), 64'd0);
    check("mp_if_ready_post", 64'(if_ready), 64'd1);

    // Full queue: fifth push refused, pop+push on full accepts no push
    for (int i = 0; i < 4; i++) begin
      set_if(1'b1, 32'h400 + 32'(4 * i), 32'h404 + 32'(4 * i), 1'b0);
      cyc();
    end
    check("full_if_ready", 64'(if_ready), 64'd0);
    check("full_ex_ready", 64'(ex_ready), 64'd1);
    set_if(1'b1, 32'h500, 32'h504, 1'b0); cyc();
    check("full_5th_refused", 64'(if_ready), 64'd0);
    set_ex(1'b1, 32'h400, 32'h404); cyc();
    set_if(1'b0, '0, '0, 1'b0);
    check("full_pop_redir", 64'(redirect_valid), 64'd0);
    check("full_after_pop", 64'(if_ready), 64'd1);
    for (int i = 1; i < 4; i++) begin
      set_ex(1'b1, 32'h400 + 32'(4 * i), 32'h404 + 32'(4 * i)); cyc();
      check("full_drain_redir", 64'(redirect_valid), 64'd0);
    end
    idle();
    check("full_drained", 64'(ex_ready), 64'd0);
    check("full_br", 64'(br_count), 64'd2);
    check("full_mis", 64'(mispred_count), 64'd1);

    // Pointer wrap: 10 entries streamed through in order, odd ones are branches
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) set_if(1'b1, 32'h1000 + 32'(8 * i), 32'h1004 + 32'(8 * i), 1'(i % 2));
      else        set_if(1'b0, '0, '0, 1'b0);
      if (i > 0)  set_ex(1'b1, 32'h1000 + 32'(8 * (i - 1)), 32'h1004 + 32'(8 * (i - 1)));
      else        set_ex(1'b0, '0, '0);
      cyc();
      check("wrap_redir", 64'(redirect_valid), 64'd0);
    end
    idle();
    check("wrap_br", 64'(br_count), 64'd7);
    check("wrap_mis", 64'(mispred_count), 64'd1);
    check("wrap_empty", 64'(ex_ready), 64'd0);

    // Empty pop is ignored
    set_ex(1'b1, 32'h0, 32'h999); cyc();
    idle();
    check("epop_redir", 64'(redirect_valid), 64'd0);
    check("epop_mis", 64'(mispred_count), 64'd1);
    check("epop_br", 64'(br_count), 64'd7);
    check("epop_ex_ready", 64'(ex_ready), 64'd0);

    // Reset while a redirect is pending
    set_if(1'b1, 32'h600, 32'h604, 1'b1); cyc();
    idle();
    set_ex(1'b1, 32'h600, 32'h700); cyc();
    idle();
    check("rr_redir_v", 64'(redirect_valid), 64'd1);
    check("rr_redir_pc", 64'(redirect_pc), 64'h700);
    check("rr_mis_pre", 64'(mispred_count), 64'd2);
    rst_n = 1'b0; cyc();
    rst_n = 1'b1;
    check("rr_redir_v_clr", 64'(redirect_valid), 64'd0);
    check("rr_redir_pc_clr", 64'(redirect_pc), 64'd0);
    check("rr_br_clr", 64'(br_count), 64'd0);
    check("rr_mis_clr", 64'(mispred_count), 64'd0);
    check("rr_if_ready", 64'(if_ready), 64'd1);
    check("rr_ex_ready", 64'(ex_ready), 64'd0);

    // Saturation: 20 correctly predicted branches
    for (int i = 0; i <= 20; i++) begin
      if (i < 20) set_if(1'b1, 32'h2000 + 32'(4 * i), 32'h2000 - 32'(4 * i), 1'b1);
      else        set_if(1'b0, '0, '0, 1'b0);
      if (i > 0)  set_ex(1'b1, 32'h2000 + 32'(4 * (i - 1)), 32'h2000 - 32'(4 * (i - 1)));
      else        set_ex(1'b0, '0, '0);
      cyc();
    end
    idle();
    check("sat_br", 64'(s_br_count), 64'd15);
    check("sat_mis", 64'(s_mispred_count), 64'd0);
    check("sat_redir", 64'(s_redirect_valid), 64'd0);
    check("wide_br", 64'(br_count), 64'd20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
